nway_wb_cache: RTL

Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement and multi-word blocks. It sits between the CPU load/store path and data memory and generalises the earlier single-word, 2-way, write-only-fill cache. It adds configurable associativity and block size, dirty tracking, and a stalling handshake on both sides, with a burst-per-word memory FSM for victim writeback and block refill.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_lru.sv | 54 +++++
 rtl/nway_wb_cache.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the N-way write-back cache.
// Latency: none (types and pure functions); backpressure: not applicable.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cache_state_t;

    function automatic logic [63:0] addr_off(input logic [63:0] a, input int off_w);
        return (a >> 2) & ((64'd1 << off_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_set(input logic [63:0] a, input int set_w, input int off_w);
        return (a >> (2 + off_w)) & ((64'd1 << set_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int set_w, input int off_w);
        return a >> (2 + off_w + set_w);
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age store: one age per way per set, 0 = MRU; victim is the oldest way of rd_set.
// Latency: victim is combinational, touch lands at the next edge; backpressure: none.
module cache_lru #(
    parameter int WAYS  = 2,
    parameter int SETS  = 4,
    parameter int SET_W = $clog2(SETS),
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SET_W-1:0] rd_set,
    output logic [WAY_W-1:0] victim_way,
    input  logic             touch_en,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way
);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] age_d [SETS][WAYS];

    always_comb begin
        age_d = age_q;
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                    age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
                end
            end
            age_d[touch_set][touch_way] = '0;
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[rd_set][w] == WAY_W'(WAYS - 1)) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back/write-allocate cache with true-LRU and per-word burst fill.
// Latency: hit 0 cycles, miss 1+WORDS (clean) or 1+2*WORDS (dirty); mem_ready low stalls the beat in place.
module nway_wb_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int WORDS      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - SET_W - OFF_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    cache_state_t          state_q, state_d;
    logic [OFF_W-1:0]      beat_q, beat_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic                  valid_q [SETS][WAYS];
    logic                  valid_d [SETS][WAYS];
    logic                  dirty_q [SETS][WAYS];
    logic                  dirty_d [SETS][WAYS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]      tag_d   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][WORDS];
    logic [DATA_WIDTH-1:0] data_d  [SETS][WAYS][WORDS];

    logic [TAG_W-1:0] req_tag;
    logic [SET_W-1:0] req_set;
    logic [OFF_W-1:0] req_off;
    logic             hit, free, last_beat, touch_en;
    logic [WAY_W-1:0] hit_way, free_way, lru_way, touch_way;

    assign req_tag   = TAG_W'(addr_tag(64'(cpu_addr), SET_W, OFF_W));
    assign req_set   = SET_W'(addr_set(64'(cpu_addr), SET_W, OFF_W));
    assign req_off   = OFF_W'(addr_off(64'(cpu_addr), OFF_W));
    assign last_beat = (beat_q == OFF_W'(WORDS - 1));

    // Downward scan so the lowest-index match / invalid way wins.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_set][w]) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_set     (req_set),
        .victim_way (lru_way),
        .touch_en   (touch_en),
        .touch_set  (req_set),
        .touch_way  (touch_way)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        victim_d  = victim_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_d     = tag_q;
        data_d    = data_q;
        touch_en  = 1'b0;
        touch_way = hit_way;
        case (state_q)
            IDLE: begin
                if (cpu_req && hit) begin
                    touch_en = 1'b1;
                    if (cpu_we) begin
                        data_d[req_set][hit_way][req_off] = cpu_wdata;
                        dirty_d[req_set][hit_way]         = 1'b1;
                    end
                end else if (cpu_req) begin
                    victim_d = free ? free_way : lru_way;
                    beat_d   = '0;
                    state_d  = (valid_q[req_set][victim_d] && dirty_q[req_set][victim_d])
                               ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    if (last_beat) state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_ready) begin
                    data_d[req_set][victim_q][beat_q] = mem_rdata;
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    if (last_beat) begin
                        tag_d[req_set][victim_q]   = req_tag;
                        valid_d[req_set][victim_q] = 1'b1;
                        dirty_d[req_set][victim_q] = 1'b0;
                        touch_en                   = 1'b1;
                        touch_way                  = victim_q;
                        state_d                    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of stale state.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    cpu_ready = cpu_req && hit;
                    if (cpu_req && hit) cpu_rdata = data_q[req_set][hit_way][req_off];
                end
                WRITEBACK: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag_q[req_set][victim_q], req_set, beat_q, 2'b00};
                    mem_wdata = data_q[req_set][victim_q][beat_q];
                end
                REFILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {req_tag, req_set, beat_q, 2'b00};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

endmodule
